// File: rtl/dcp_arb_if.sv
// DCP arbiter bus: the requester handshakes from the CPU and DVMA, plus the DCP strobe/ready
// signals. master = requester/DCP side, slave = arbiter side.
interface dcp_arb_if;
  logic cpu_rd;
  logic cpu_wr;
  logic cpu_la1;
  logic cpu_ack;
  logic dma_rd;
  logic dma_wr;
  logic dma_la1;
  logic dma_ack;
  logic dcp_rdy;
  logic mas;
  logic mds;
  logic dcp_wr;
  logic owner;
  logic busy;
  logic dcp_err;

  modport master (
    output cpu_rd, cpu_wr, cpu_la1, dma_rd, dma_wr, dma_la1, dcp_rdy,
    input  cpu_ack, dma_ack, mas, mds, dcp_wr, owner, busy, dcp_err
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_la1, dma_rd, dma_wr, dma_la1, dcp_rdy,
    output cpu_ack, dma_ack, mas, mds, dcp_wr, owner, busy, dcp_err
  );
endinterface

// File: rtl/dcp_arb.sv
// DCP port arbiter and strobe sequencer. Grants the port to the CPU or DVMA (round-robin on a
// tie), runs one address (mas) or data (mds) strobe, then returns a one-cycle ack.
module dcp_arb #(
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic      clk,
  input logic      sanity,
  dcp_arb_if.slave bus
);

  localparam int unsigned     CntW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] StrobeCnt  = CntW'(STROBE_CYCLES);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StAck, StRecov} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;   // 0 = CPU, 1 = DVMA
  logic            dir_q, dir_d;       // 1 = write
  logic            addr_q, addr_d;     // 1 = address cycle (mas), 0 = data cycle (mds)
  logic            tmo_q, tmo_d;
  logic            last_q, last_d;     // requester granted last
  logic [CntW-1:0] cnt_q, cnt_d;

  logic cpu_act;
  logic dma_act;
  logic grant_dma;
  logic own_act;

  assign cpu_act = bus.cpu_rd | bus.cpu_wr;
  assign dma_act = bus.dma_rd | bus.dma_wr;
  // On a tie the requester not granted last wins.
  assign grant_dma = (cpu_act & dma_act) ? ~last_q : dma_act;
  assign own_act   = owner_q ? dma_act : cpu_act;

  // State and transaction registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (sanity) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      dir_q   <= 1'b0;
      addr_q  <= 1'b0;
      tmo_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: grant, strobe timing and recovery.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (cpu_act | dma_act) begin
          owner_d = grant_dma;
          addr_d  = grant_dma ? bus.dma_la1 : bus.cpu_la1;
          // rd and wr both high is a read.
          dir_d   = grant_dma ? (bus.dma_wr & ~bus.dma_rd) : (bus.cpu_wr & ~bus.cpu_rd);
          tmo_d   = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = CntOne;
        state_d = StStrobe;
      end
      StStrobe: begin
        if (cnt_q != '1) cnt_d = cnt_q + CntOne;
        if (addr_q) begin
          if (cnt_q == StrobeCnt) state_d = StAck;
        end else if ((cnt_q >= StrobeCnt) && bus.dcp_rdy) begin
          state_d = StAck;
        end else if (cnt_q == TimeoutCnt) begin
          tmo_d   = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        last_d  = owner_q;
        state_d = StRecov;
      end
      StRecov: begin
        if (!own_act) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state and latched transaction.
  always_comb begin
    bus.busy    = (state_q != StIdle);
    bus.mas     = (state_q == StStrobe) &  addr_q;
    bus.mds     = (state_q == StStrobe) & ~addr_q;
    bus.cpu_ack = (state_q == StAck) & ~owner_q;
    bus.dma_ack = (state_q == StAck) &  owner_q;
    bus.dcp_err = (state_q == StAck) &  tmo_q;
    bus.dcp_wr  = dir_q;
    bus.owner   = owner_q;
  end

endmodule

// File: doc/dcp_arb.md
# dcp_arb

Arbiter and strobe sequencer for the 120 CPU board's DCP port. Shares the port between two requesters, the CPU and DVMA, and runs one transaction at a time. Each transaction is either an address cycle (mas) or a data cycle (mds, terminated by dcp_rdy or a timeout). It returns a one-cycle ack to the winning requester and sits between the requesters and the dcpctl strobe/ack logic.

## Interface
- STROBE_CYCLES, default 2: minimum strobe width in clocks. Legal range is 1..TIMEOUT_CYCLES-1.
- TIMEOUT_CYCLES, default 15: maximum data-strobe length before a forced termination.
- clk  in  1  board clock. All logic is on the rising edge.
- sanity  in  1  reset. Synchronous, active-high.
- cpu_rd, cpu_wr  in  1  CPU request, read or write. Level, held until ack.
- cpu_la1  in  1  CPU cycle type: 1 = address cycle, 0 = data cycle.
- cpu_ack  out  1  one-cycle completion to the CPU.
- dma_rd, dma_wr, dma_la1  in  1  DVMA request and cycle type. Same rules as the CPU inputs.
- dma_ack  out  1  one-cycle completion to DVMA.
- dcp_rdy  in  1  DCP data-ready. Sampled only while mds is high.
- mas  out  1  address strobe to the DCP.
- mds  out  1  data strobe to the DCP.
- dcp_wr  out  1  direction of the current transaction: 1 = write.
- owner  out  1  current grant: 0 = CPU, 1 = DVMA.
- busy  out  1  high in every state except IDLE.
- dcp_err  out  1  one-cycle pulse, coincident with ack, on a timeout.

## Operation
- States: IDLE, SETUP, STROBE, ACK, RECOV.
- **IDLE**
  - A requester is active when rd|wr is high.
  - If one requester is active, it is granted.
  - If both are active, round-robin: the requester not granted last wins.
  - On grant, latch owner, type (la1), and dir = wr & ~rd. rd&wr both high is treated as a read.
  - Next state: SETUP.
- **SETUP**
  - One cycle. dcp_wr and owner are valid, both strobes are low. Next state: STROBE.
- **STROBE**
  - Address type: mas=1, mds=0.
  - Data type: mds=1, mas=0.
  - Counter cnt starts at 1 in the first STROBE cycle and increments each cycle.
  - Address type: leave when cnt==STROBE_CYCLES.
  - Data type: leave when cnt>=STROBE_CYCLES and dcp_rdy==1 in that cycle.
  - Data type: otherwise leave when cnt==TIMEOUT_CYCLES and set the timeout flag.
  - Next state: ACK.
- **ACK**
  - Strobes low.
  - The owner's ack is 1 for exactly one cycle.
  - dcp_err = timeout flag.
  - The last-grant register is updated to owner.
  - Next state: RECOV.
- **RECOV**
  - Strobes low. Stay until the owner's rd and wr are both low, then go to IDLE.
  - The other requester's pending request is not considered until IDLE.
- Latched type and direction ignore requester input changes after grant.
- cnt width is clog2(TIMEOUT_CYCLES+1). cnt saturates, never wraps.
- mas and mds are never high in the same cycle. Neither is high outside STROBE.

## Timing
- Reset (sanity=1 at an edge):
  - Next cycle, state is IDLE.
  - mas, mds, cpu_ack, dma_ack, dcp_err, busy, dcp_wr and owner are all 0.
  - cnt = 0, timeout flag cleared.
  - Last grant = DVMA, so the CPU wins the first tie.
  - Applies mid-transaction too: the strobe drops the next cycle and no ack is issued.
- Cycle numbering: request seen high in IDLE = cycle 0.
  - Cycle 1: SETUP, busy=1.
  - Cycles 2..1+STROBE_CYCLES: strobe high (minimum).
  - Best-case ack: cycle 2+STROBE_CYCLES.
- Data cycle with dcp_rdy first high in STROBE cycle k (k>=STROBE_CYCLES): ack in cycle 2+k.
- Timeout: mds high in cycles 2..1+TIMEOUT_CYCLES; ack and dcp_err in cycle 2+TIMEOUT_CYCLES.
- Earliest return to IDLE: cycle 4+STROBE_CYCLES, when the request drops in the ack cycle.
- Back-to-back: minimum request-to-request spacing is 4+STROBE_CYCLES cycles.
- Simultaneous new requests in IDLE are arbitrated round-robin. A request arriving during busy waits with no loss.

## Test plan
- **Reset.** Hold sanity=1 for 3 cycles during a data strobe.
  - The cycle after the first reset edge, all outputs are 0 and state is IDLE.
  - No ack is issued.
- **CPU address read.** cpu_rd=1, cpu_la1=1 at cycle 0, defaults.
  - mas=1 in cycles 2–3.
  - cpu_ack=1 in cycle 4 only.
  - dcp_wr=0, dcp_err=0.
- **DVMA data write with slow DCP.** dma_wr=1, dma_la1=0; dcp_rdy rises in cycle 6.
  - mds=1 in cycles 2–6.
  - dma_ack and dcp_wr=1 in cycle 7.
  - owner=1 throughout.
- **Timeout.** cpu_rd=1, cpu_la1=0, dcp_rdy held 0.
  - mds=1 in cycles 2–16.
  - cpu_ack and dcp_err both 1 in cycle 17.
- **Round-robin.** CPU and DVMA both request continuously from reset.
  - Grants alternate CPU, DVMA, CPU, DVMA.
  - Each ack goes to the correct requester only.
  - mas/mds are never both high.
- **Request held past ack.** The CPU keeps cpu_rd=1 for 3 cycles after ack.
  - State stays RECOV. No second transaction starts.
  - IDLE is reached the cycle after cpu_rd drops.
